buffer_reader: RTL and testbench
================================

# buffer_reader

Read-side companion to the sample buffer. On a `start` pulse it snapshots the buffer's min/max/avg statistics, sweeps the buffer's read `address` across `sampleCount` entries, and streams a framed byte sequence out over a valid/ready handshake. The frame is header, min, max, avg, then the samples, then an optional checksum. It sits between the temperature sample buffer and the downstream transmit/reporting logic.

## Interface
- `addressWidth`, default 8: width of the buffer read address.
- `sampleCount`, default 8: samples per frame; legal range 1..2^addressWidth.
- `HEADER`, default 8'hA5: first byte of every frame.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  frame request; sampled only in IDLE.
- `address`  out  addressWidth  buffer read address.
- `buff_out`  in  8  buffer read data; combinational from `address`.
- `buff_min`  in  8  buffer minimum statistic.
- `buff_max`  in  8  buffer maximum statistic.
- `buff_avg`  in  8  buffer average statistic.
- `tx_data`  out  8  frame byte; registered.
- `tx_valid`  out  1  `tx_data` is valid; registered.
- `tx_ready`  in  1  downstream accepts the byte.
- `busy`  out  1  frame in progress.
- `done`  out  1  one-cycle pulse after the final byte is accepted.

## Operation
- FSM states: IDLE, HDR, MIN, MAX, AVG, SAMP, CSUM, DONE.
- IDLE + `start`:
  - capture `buff_min`, `buff_max`, `buff_avg` into snapshot registers;
  - load `tx_data`=HEADER and set `tx_valid`=1;
  - go to HDR.
- A byte transfers on any cycle with `tx_valid && tx_ready`. On a transfer, the next byte is loaded into `tx_data` on the same edge, so throughput is one byte per cycle.
- Byte order:
  - HDR → MIN (snapshot min) → MAX (snapshot max) → AVG (snapshot avg);
  - then `sampleCount` samples;
  - then CSUM (macro on) or DONE (macro off).
- Sample phase:
  - `address` always points at the next sample to load;
  - when sample k is loaded from `buff_out`, `address` becomes k+1;
  - after the last sample is loaded, `address` returns to 0;
  - `address` is 0 outside the sample phase.
- Sample index counter is addressWidth+1 bits wide, so `sampleCount` = 2^addressWidth does not wrap early.
- Samples are read live and are not snapshotted. Min/max/avg are frozen at `start`.
- While `tx_valid`=1 and `tx_ready`=0: `tx_data`, `tx_valid`, `address` and the state all hold.
- After the final transfer, `tx_valid` drops and the FSM enters DONE:
  - `done`=1 and `busy`=0 for exactly one cycle;
  - then the FSM returns to IDLE.
- `start` is ignored outside IDLE, including during DONE.
- `busy`=1 in every state except IDLE and DONE.

## Timing
- All outputs are 0 in the cycle after `reset` is sampled high: `address`, `tx_data`, `tx_valid`, `busy`, `done`, snapshots, checksum. State = IDLE.
- Reset mid-frame aborts immediately: no `done`, the frame is truncated, and downstream must resynchronise on HEADER.
- `start` sampled at edge 0 → header valid from cycle 1.
- With `tx_ready` held high:
  - frame occupies 4+sampleCount (+1 with checksum) consecutive cycles;
  - `done` is high in the cycle after the last transfer.
- `tx_ready` may toggle arbitrarily, with no combinational path from `tx_ready` to `tx_valid`.

## Configuration
- Macro `BUFFER_READER_CHECKSUM_EN`.
- Defined:
  - an 8-bit running XOR of every transferred byte, header through last sample, is cleared at `start`;
  - it is sent as the final byte in state CSUM;
  - frame length is 5+sampleCount.
- Undefined:
  - CSUM state and XOR register are absent;
  - AVG/SAMP go straight to DONE;
  - frame length is 4+sampleCount.

## Test plan
- Checksum, `sampleCount`=4, macro defined:
  - setup: buffer = 0A,14,1E,28, min=03, max=40, avg=19, `tx_ready` tied high, pulse `start`;
  - required: bytes A5,03,40,19,0A,14,1E,28,D7 on cycles 1–9;
  - required: `address` 0,1,2,3,0 across the sample bytes;
  - required: `done` high on cycle 10 only.
- Same stimulus, macro undefined → bytes A5,03,40,19,0A,14,1E,28; `done` on cycle 9.
- Backpressure:
  - stimulus: drop `tx_ready` for 3 cycles while the MAX byte (40) is presented;
  - required: `tx_data`=40 and `tx_valid`=1 held all 3 cycles; frame completes 3 cycles later, byte stream unchanged.
- Snapshot:
  - stimulus: change `buff_max` 40→7F two cycles after `start`;
  - required: frame still carries 40.
- `start` re-pulsed during SAMP and during DONE → ignored; exactly one frame emitted.
- Reset mid-frame:
  - stimulus: assert `reset` during SAMP;
  - required: next cycle `tx_valid`=0, `busy`=0, `address`=0, `done`=0;
  - required: a subsequent `start` produces a full, correct frame starting with A5.

Source files
------------

// File: rtl/buffer_reader.sv
`default_nettype none
// ============================================================================
// Module   : buffer_reader
// Purpose  : Read-side companion to the sample buffer. On a start pulse it
//            freezes the buffer's min/max/avg statistics, sweeps the buffer
//            read address across sampleCount entries and streams the frame
//            HEADER, min, max, avg, samples[, checksum] over a valid/ready
//            handshake at up to one byte per cycle.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   addressWidth  width of the buffer read address
//   sampleCount   samples per frame, 1..2**addressWidth
//   HEADER        first byte of every frame
// Ports:
//   clk       in   single clock, rising edge
//   reset     in   synchronous active-high reset
//   start     in   frame request, honoured only in IDLE
//   address   out  buffer read address (points at the next sample to load)
//   buff_out  in   buffer read data, combinational from address
//   buff_min  in   buffer minimum statistic
//   buff_max  in   buffer maximum statistic
//   buff_avg  in   buffer average statistic
//   tx_data   out  frame byte (registered)
//   tx_valid  out  tx_data valid (registered)
//   tx_ready  in   downstream accepts the byte
//   busy      out  frame in progress
//   done      out  one-cycle pulse after the final byte is accepted
// Configuration:
//   BUFFER_READER_CHECKSUM_EN  when defined, appends an 8-bit XOR of every
//                              preceding frame byte as the last byte.
// ============================================================================
module buffer_reader #(
  parameter int         addressWidth = 8,
  parameter int         sampleCount  = 8,
  parameter logic [7:0] HEADER       = 8'hA5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  output logic [addressWidth-1:0] address,
  input  logic [7:0]              buff_out,
  input  logic [7:0]              buff_min,
  input  logic [7:0]              buff_max,
  input  logic [7:0]              buff_avg,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic                    busy,
  output logic                    done
);

  // One extra bit so sampleCount == 2**addressWidth is representable.
  localparam logic [addressWidth:0] LAST_IDX = (addressWidth+1)'(sampleCount);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    MIN  = 3'd2,
    MAX  = 3'd3,
    AVG  = 3'd4,
    SAMP = 3'd5,
`ifdef BUFFER_READER_CHECKSUM_EN
    CSUM = 3'd6,
`endif
    DONE = 3'd7
  } state_t;

  state_t                  state, state_next;
  logic [7:0]              tx_data_next;
  logic                    tx_valid_next;
  logic [addressWidth-1:0] address_next;
  logic [addressWidth:0]   idx, idx_next, idx_inc;   // samples loaded so far
  logic [7:0]              snap_min, snap_max, snap_avg;
  logic                    snap_load;
  logic                    xfer;

`ifdef BUFFER_READER_CHECKSUM_EN
  logic [7:0]              csum, csum_next;
`endif

  assign xfer    = tx_valid & tx_ready;
  assign idx_inc = idx + 1'b1;
  assign busy    = (state != IDLE) && (state != DONE);
  assign done    = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      address  <= '0;
      idx      <= '0;
      snap_min <= '0;
      snap_max <= '0;
      snap_avg <= '0;
`ifdef BUFFER_READER_CHECKSUM_EN
      csum     <= '0;
`endif
    end else begin
      state    <= state_next;
      tx_data  <= tx_data_next;
      tx_valid <= tx_valid_next;
      address  <= address_next;
      idx      <= idx_next;
      if (snap_load) begin
        snap_min <= buff_min;
        snap_max <= buff_max;
        snap_avg <= buff_avg;
      end
`ifdef BUFFER_READER_CHECKSUM_EN
      csum     <= csum_next;
`endif
    end
  end

  always_comb begin
    state_next    = state;
    tx_data_next  = tx_data;
    tx_valid_next = tx_valid;
    address_next  = address;
    idx_next      = idx;
    snap_load     = 1'b0;
`ifdef BUFFER_READER_CHECKSUM_EN
    csum_next     = csum;
    // Fold every accepted byte except the checksum itself.
    if (xfer && (state != CSUM))
      csum_next = csum ^ tx_data;
`endif

    case (state)
      IDLE: begin
        if (start) begin
          snap_load     = 1'b1;
          tx_data_next  = HEADER;
          tx_valid_next = 1'b1;
          address_next  = '0;
          idx_next      = '0;
`ifdef BUFFER_READER_CHECKSUM_EN
          csum_next     = '0;
`endif
          state_next    = HDR;
        end
      end
      HDR: begin
        if (xfer) begin
          tx_data_next = snap_min;
          state_next   = MIN;
        end
      end
      MIN: begin
        if (xfer) begin
          tx_data_next = snap_max;
          state_next   = MAX;
        end
      end
      MAX: begin
        if (xfer) begin
          tx_data_next = snap_avg;
          state_next   = AVG;
        end
      end
      AVG: begin
        // address is 0 here, so buff_out already presents sample 0.
        if (xfer) begin
          tx_data_next = buff_out;
          idx_next     = (addressWidth+1)'(1);
          address_next = (LAST_IDX == (addressWidth+1)'(1)) ? '0 : addressWidth'(1);
          state_next   = SAMP;
        end
      end
      SAMP: begin
        if (xfer) begin
          if (idx == LAST_IDX) begin
            idx_next      = '0;
`ifdef BUFFER_READER_CHECKSUM_EN
            tx_data_next  = csum_next;
            state_next    = CSUM;
`else
            tx_data_next  = '0;
            tx_valid_next = 1'b0;
            state_next    = DONE;
`endif
          end else begin
            tx_data_next = buff_out;
            idx_next     = idx_inc;
            // Park the address at 0 once the last sample has been loaded.
            address_next = (idx_inc == LAST_IDX) ? '0 : idx_inc[addressWidth-1:0];
          end
        end
      end
`ifdef BUFFER_READER_CHECKSUM_EN
      CSUM: begin
        if (xfer) begin
          tx_data_next  = '0;
          tx_valid_next = 1'b0;
          state_next    = DONE;
        end
      end
`endif
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next    = IDLE;
        tx_valid_next = 1'b0;
        tx_data_next  = '0;
        address_next  = '0;
        idx_next      = '0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_buffer_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_buffer_reader
// Purpose  : Directed self-checking bench for buffer_reader with
//            addressWidth=2, sampleCount=4 (full address range). Covers reset
//            state, a nominal frame, backpressure on the MAX byte, snapshot
//            freezing of buff_max, start re-pulses during SAMP and DONE, and
//            reset in the middle of a frame.
// Revision : 1.0 - initial release
// ============================================================================
module tb_buffer_reader;

  localparam int AW = 2;
  localparam int SC = 4;
`ifdef BUFFER_READER_CHECKSUM_EN
  localparam int LEN = 9;
`else
  localparam int LEN = 8;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] address;
  logic [7:0]    buff_out;
  logic [7:0]    buff_min = 8'h03;
  logic [7:0]    buff_max = 8'h40;
  logic [7:0]    buff_avg = 8'h19;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready = 1'b1;
  logic          busy;
  logic          done;

  logic [7:0] mem [0:SC-1];
  logic [7:0] exp_bytes [0:8];

  int tests  = 0;
  int failed = 0;

  assign buff_out = mem[address];

  always #5 clk = ~clk;

  buffer_reader #(
    .addressWidth(AW),
    .sampleCount (SC),
    .HEADER      (8'hA5)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .address  (address),
    .buff_out (buff_out),
    .buff_min (buff_min),
    .buff_max (buff_max),
    .buff_avg (buff_avg),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .busy     (busy),
    .done     (done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Address presented while frame byte i is on tx_data.
  function automatic logic [31:0] exp_addr(input int i);
    if (i >= 4 && i <= 6) return 32'(i - 3);
    return 32'd0;
  endfunction

  // Requests one frame and checks every byte; optional stall, snapshot
  // disturbance and stray start pulses.
  task automatic run_frame(input int stall_idx, input int stall_len,
                           input int restart_idx, input bit snap_change,
                           input bit start_in_done);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < LEN; i++) begin
      if (snap_change && i == 1) buff_max = 8'h7F;
      if (i == stall_idx) begin
        tx_ready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          chk("stall_data", tx_data, exp_bytes[i]);
          chk("stall_valid", tx_valid, 1);
          chk("stall_addr", address, exp_addr(i));
          step();
        end
        tx_ready = 1'b1;
      end
      if (i == restart_idx) start = 1'b1;
      chk($sformatf("byte%0d", i), tx_data, exp_bytes[i]);
      chk($sformatf("valid%0d", i), tx_valid, 1);
      chk($sformatf("busy%0d", i), busy, 1);
      chk($sformatf("nodone%0d", i), done, 0);
      chk($sformatf("addr%0d", i), address, exp_addr(i));
      step();
      start = 1'b0;
    end
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 0);
    chk("done_valid", tx_valid, 0);
    if (start_in_done) start = 1'b1;
    step();
    start = 1'b0;
    chk("post_done", done, 0);
    chk("post_busy", busy, 0);
    chk("post_valid", tx_valid, 0);
    step();
    chk("idle_valid", tx_valid, 0);
    chk("idle_busy", busy, 0);
    buff_max = 8'h40;
  endtask

  initial begin
    mem[0] = 8'h0A; mem[1] = 8'h14; mem[2] = 8'h1E; mem[3] = 8'h28;
    exp_bytes[0] = 8'hA5; exp_bytes[1] = 8'h03; exp_bytes[2] = 8'h40;
    exp_bytes[3] = 8'h19; exp_bytes[4] = 8'h0A; exp_bytes[5] = 8'h14;
    exp_bytes[6] = 8'h1E; exp_bytes[7] = 8'h28; exp_bytes[8] = 8'hD7;

    // Reset state
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    chk("rst_valid", tx_valid, 0);
    chk("rst_data", tx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_addr", address, 0);

    // Nominal frame, tx_ready held high
    run_frame(-1, 0, -1, 1'b0, 1'b0);

    // Backpressure on MAX byte plus buff_max change after start
    run_frame(2, 3, -1, 1'b1, 1'b0);

    // start re-pulsed during SAMP and during DONE
    run_frame(-1, 0, 5, 1'b0, 1'b1);

    // Reset mid-frame during SAMP
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("mid_busy_pre", busy, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_valid", tx_valid, 0);
    chk("mid_busy", busy, 0);
    chk("mid_addr", address, 0);
    chk("mid_done", done, 0);
    chk("mid_data", tx_data, 0);
    step();
    chk("mid_idle_valid", tx_valid, 0);

    // Full frame after the abort
    run_frame(-1, 0, -1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
